// File: rtl/pl_ctrl_pkg.sv
// pl_ctrl_pkg: shared FSM encoding and select constants for pipeline_ctrl
package pl_ctrl_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FAULT} state_e;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W = 2'b01;
    localparam logic [1:0] FWD_M = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: E-stage operand forward select; rs_e vs M/W destinations, fwd = FWD_M/FWD_W/FWD_RF
import pl_ctrl_pkg::*;
module fwd_sel (
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    always_comb
        fwd = (reg_write_m && rd_m != 5'd0 && rd_m == rs_e) ? FWD_M :
              (reg_write_w && rd_w != 5'd0 && rd_w == rs_e) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard unit (forwarding, load-use, branch flush, memory-wait/timeout); ports: clk, reset, stage register indices, RegWriteM/W, ResultSrcE, PCSrcE, MemReqM/MemReadyM in; Stall*/Flush*, ForwardAE/BE, MemFault out; PIPE_PERF_COUNTERS_EN adds StallCount/FlushCount
import pl_ctrl_pkg::*;
module pipeline_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemFault
`ifdef PIPE_PERF_COUNTERS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);
    localparam logic [7:0] LIM = 8'(WAIT_LIMIT - 1);
    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic lu_q, lu_d;
    logic mem_stall, load_use, lu_act;
    logic [1:0] fa, fb;
    fwd_sel u_fwd_a (.rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fa));
    fwd_sel u_fwd_b (.rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fb));
    always_comb begin
        mem_stall = MemReqM & ~MemReadyM;
        load_use = ResultSrcE == RES_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        // the stall inserts a bubble into E, so a hazard still visible the next cycle is the same one
        lu_act = load_use & ~PCSrcE & ~lu_q;
        state_d = state_q;
        cnt_d = 8'd0;
        lu_d = 1'b0;
        {StallF, StallD, StallE, StallM, StallW} = 5'b0;
        {FlushD, FlushE, FlushM, FlushW} = 4'b0;
        ForwardAE = fa;
        ForwardBE = fb;
        MemFault = state_q == ST_FAULT;
        if (state_q == ST_RUN)
            state_d = mem_stall ? ST_WAIT : ST_RUN;
        else if (state_q == ST_WAIT) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            state_d = MemReadyM ? ST_RUN : (mem_stall && cnt_q >= LIM) ? ST_FAULT : ST_WAIT;
        end else
            cnt_d = cnt_q;
        if (reset) begin
            {FlushD, FlushE, FlushM, FlushW} = 4'b1111;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (state_q == ST_FAULT || mem_stall) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW = 1'b1;
            ForwardAE = (state_q == ST_FAULT) ? FWD_RF : fa;
            ForwardBE = (state_q == ST_FAULT) ? FWD_RF : fb;
        end else begin
            StallF = lu_act;
            StallD = lu_act;
            FlushD = PCSrcE;
            FlushE = PCSrcE | lu_act;
            lu_d = lu_act;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q <= 8'd0;
            lu_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            lu_q <= lu_d;
        end
    end
`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    always_comb begin
        stall_count_d = stall_count_q + 32'(StallF && stall_count_q != 32'hFFFFFFFF);
        flush_count_d = flush_count_q + 32'((FlushD | FlushE) && flush_count_q != 32'hFFFFFFFF);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end
    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
    localparam int WL = 4;
    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ResultSrcE;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW, MemFault;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] StallCount, FlushCount;
`endif
    int checks = 0;
    int passed = 0;
    logic m_fault, m_waiting, m_lu_prev;
    int m_w;
    int unsigned m_sc, m_fc;
    logic [13:0] act;
    assign act = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW, ForwardAE, ForwardBE, MemFault};

    pipeline_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemFault(MemFault)
`ifdef PIPE_PERF_COUNTERS_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (rs != 0 && RegWriteM && RdM == rs) return 2'b10;
        if (rs != 0 && RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {load-use taken, StallF..W, FlushD..W, ForwardAE, ForwardBE, MemFault}
    function automatic logic [14:0] model_out();
        logic ms, haz, lu;
        ms = MemReqM && !MemReadyM;
        haz = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (reset) return {1'b0, 5'b00000, 4'b1111, 4'b0000, m_fault};
        if (m_fault) return {1'b0, 5'b11110, 4'b0001, 4'b0000, 1'b1};
        if (ms) return {1'b0, 5'b11110, 4'b0001, fwd_of(Rs1E), fwd_of(Rs2E), 1'b0};
        lu = haz && !PCSrcE && !m_lu_prev;
        return {lu, lu, lu, 3'b000, PCSrcE, PCSrcE | lu, 2'b00, fwd_of(Rs1E), fwd_of(Rs2E), 1'b0};
    endfunction

    task automatic tick();
        logic [14:0] e;
        @(posedge clk);
        e = model_out();
        if (reset) begin
            m_fault = 0; m_waiting = 0; m_w = 0; m_lu_prev = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e[13]) m_sc++;
            if (e[8] || e[7]) m_fc++;
            m_lu_prev = e[14];
            if (!m_fault) begin
                if (!m_waiting) begin
                    if (MemReqM && !MemReadyM) begin m_waiting = 1; m_w = 0; end
                end else if (MemReadyM) m_waiting = 0;
                else if (MemReqM && m_w >= WL - 1) m_fault = 1;
                else m_w++;
            end
        end
        #2;
    endtask

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
        ResultSrcE = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; Rs1E = 5; RdM = 5; RegWriteM = 1; #1;
        checks++; if ({StallF, StallD, StallE, StallM, StallW} !== 5'b0) $display("FAIL reset_stalls: got %b want 00000", {StallF, StallD, StallE, StallM, StallW}); else passed++;
        checks++; if ({FlushD, FlushE, FlushM, FlushW} !== 4'b1111) $display("FAIL reset_flushes: got %b want 1111", {FlushD, FlushE, FlushM, FlushW}); else passed++;
        checks++; if (ForwardAE !== 2'b00) $display("FAIL reset_fwd: got %b want 00", ForwardAE); else passed++;
        tick(); reset = 0; idle(); #1;
        checks++; if (act !== 14'b0) $display("FAIL post_reset: got %b want 0", act); else passed++;
`ifdef PIPE_PERF_COUNTERS_EN
        checks++; if (StallCount !== 0 || FlushCount !== 0) $display("FAIL reset_counters: got %0d/%0d want 0/0", StallCount, FlushCount); else passed++;
`endif
    endtask

    task automatic test_forward();
        idle();
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
        checks++; if (ForwardAE !== 2'b10) $display("FAIL fwd_m_wins: got %b want 10", ForwardAE); else passed++;
        RegWriteM = 0; #1;
        checks++; if (ForwardAE !== 2'b01) $display("FAIL fwd_w: got %b want 01", ForwardAE); else passed++;
        Rs1E = 0; RdM = 0; RegWriteM = 1; #1;
        checks++; if (ForwardAE !== 2'b00) $display("FAIL fwd_x0: got %b want 00", ForwardAE); else passed++;
        Rs2E = 9; RdW = 9; RegWriteW = 1; #1;
        checks++; if (ForwardBE !== 2'b01) $display("FAIL fwd_b_w: got %b want 01", ForwardBE); else passed++;
        RdM = 9; #1;
        checks++; if (ForwardBE !== 2'b10) $display("FAIL fwd_b_m: got %b want 10", ForwardBE); else passed++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
        checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) $display("FAIL load_use: got %b want 1110", {StallF, StallD, FlushE, FlushD}); else passed++;
        tick(); #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL load_use_once: got %b want 000", {StallF, StallD, FlushE}); else passed++;
        idle(); tick();
    endtask

    task automatic test_branch();
        idle();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1; #1;
        checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) $display("FAIL branch_vs_lu: got %b want 1100", {FlushD, FlushE, StallF, StallD}); else passed++;
        idle(); tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1); #1;
            checks++; if (act[13:5] !== 9'b111100001) $display("FAIL mem_wait_%0d: got %b want 111100001", i, act[13:5]); else passed++;
            tick();
        end
        PCSrcE = 0; MemReadyM = 1; #1;
        checks++; if (act[13:5] !== 9'b0) $display("FAIL mem_ready: got %b want 0", act[13:5]); else passed++;
        tick(); idle(); #1;
        checks++; if (MemFault !== 1'b0) $display("FAIL mem_no_fault: got %b want 0", MemFault); else passed++;
`ifdef PIPE_PERF_COUNTERS_EN
        checks++; if (StallCount !== 32'd3) $display("FAIL stall_count: got %0d want 3", StallCount); else passed++;
`endif
        MemReqM = 1; #1;
        checks++; if (StallF !== 1'b1 || MemFault !== 1'b0) $display("FAIL mem_rerun: got %b%b want 10", StallF, MemFault); else passed++;
        idle(); tick();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        // first stalled cycle moves to WAIT, then four WAIT cycles precede FAULT
        for (int i = 0; i < WL + 1; i++) begin
            #1;
            checks++; if (MemFault !== 1'b0) $display("FAIL timeout_early_%0d: got %b want 0", i, MemFault); else passed++;
            tick();
        end
        #1;
        checks++; if (MemFault !== 1'b1) $display("FAIL timeout_fault: got %b want 1", MemFault); else passed++;
        MemReqM = 0; MemReadyM = 1; PCSrcE = 1; Rs1E = 3; RdM = 3; RegWriteM = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (act !== 14'b11110000100001) $display("FAIL fault_hold_%0d: got %b want 11110000100001", i, act); else passed++;
        end
        do_reset(); #1;
        checks++; if (MemFault !== 1'b0 || StallF !== 1'b0) $display("FAIL fault_reset: got %b%b want 00", MemFault, StallF); else passed++;
    endtask

`ifdef PIPE_PERF_COUNTERS_EN
    task automatic test_counters();
        do_reset();
        PCSrcE = 1; tick(); PCSrcE = 0; tick(); PCSrcE = 1; tick(); idle(); tick();
        checks++; if (FlushCount !== 32'd2) $display("FAIL flush_count: got %0d want 2", FlushCount); else passed++;
        checks++; if (StallCount !== 32'd0) $display("FAIL stall_count_br: got %0d want 0", StallCount); else passed++;
    endtask
`endif

    task automatic test_random();
        logic [14:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE = 2'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
            MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = ($urandom_range(0, 2) != 0);
            #1;
            e = model_out();
            checks++; if (act !== e[13:0]) $display("FAIL random_%0d: got %b want %b", i, act, e[13:0]); else passed++;
`ifdef PIPE_PERF_COUNTERS_EN
            checks++; if (StallCount !== m_sc || FlushCount !== m_fc) $display("FAIL random_cnt_%0d: got %0d/%0d want %0d/%0d", i, StallCount, FlushCount, m_sc, m_fc); else passed++;
`endif
            tick();
        end
        reset = 0;
    endtask

    initial begin
        m_fault = 0; m_waiting = 0; m_w = 0; m_lu_prev = 0; m_sc = 0; m_fc = 0;
        reset = 1; idle();
        #2;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
`ifdef PIPE_PERF_COUNTERS_EN
        test_counters();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
